// File: rtl/instruction_register_if.sv
// Bus between instruction memory/control and the instruction register:
// the load strobe and fetched word in, the four decode fields out.
interface instruction_register_if;
  logic         IL;
  logic [15:0]  IR;
  logic [15:12] opcode;
  logic [11:8]  DA;
  logic [7:4]   AA;
  logic [3:0]   BA;

  modport master (output IL, IR, input opcode, DA, AA, BA);
  modport slave  (input IL, IR, output opcode, DA, AA, BA);
endinterface

// File: rtl/instruction_register.sv
// 16-bit instruction register: captures IR on IL and exposes the stored
// word as opcode/DA/AA/BA decode fields for the control unit and register file.
module instruction_register (
  input  logic                   clk,
  input  logic                   reset,
  instruction_register_if.slave  ir_bus
);

  logic [15:0] instr_d;
  // Zero initialiser keeps the fields defined before the first reset edge.
  logic [15:0] instr_q = 16'h0000;

  always_comb begin
    instr_d = instr_q;
    if (ir_bus.IL) begin
      instr_d = ir_bus.IR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 16'h0000;
    end else begin
      instr_q <= instr_d;
    end
  end

  assign ir_bus.opcode = instr_q[15:12];
  assign ir_bus.DA     = instr_q[11:8];
  assign ir_bus.AA     = instr_q[7:4];
  assign ir_bus.BA     = instr_q[3:0];

endmodule

// File: tb/tb_instruction_register.sv
// Self-checking bench for instruction_register: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a word model.
module tb_instruction_register;

  typedef struct {
    logic        rst;
    logic        il;
    logic [15:0] ir;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  logic [15:0] model_word;
  vec_t vectors [13];

  instruction_register_if bus ();

  instruction_register dut (
    .clk    (clk),
    .reset  (reset),
    .ir_bus (bus)
  );

  always #5 clk = ~clk;

  // Drive inputs, then let one rising edge happen and settle.
  task automatic apply_stimulus(input logic rst, input logic il, input logic [15:0] ir);
    reset  = rst;
    bus.IL = il;
    bus.IR = ir;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {bus.opcode, bus.DA, bus.AA, bus.BA};
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got opcode/DA/AA/BA=%h/%h/%h/%h, expected %h/%h/%h/%h",
               name, act[15:12], act[11:8], act[7:4], act[3:0],
               exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  initial begin
    reset  = 1'b0;
    bus.IL = 1'b0;
    bus.IR = 16'h0000;

    #1;
    check_output("power_up", 16'h0000);

    vectors[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000};
    vectors[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0000};
    vectors[2]  = '{1'b0, 1'b0, 16'h8006, 16'h0000};
    vectors[3]  = '{1'b0, 1'b0, 16'h8006, 16'h0000};
    vectors[4]  = '{1'b0, 1'b0, 16'h8006, 16'h0000};
    vectors[5]  = '{1'b0, 1'b1, 16'h8006, 16'h8006};
    vectors[6]  = '{1'b0, 1'b0, 16'hFFFF, 16'h8006};
    vectors[7]  = '{1'b0, 1'b0, 16'hFFFF, 16'h8006};
    vectors[8]  = '{1'b0, 1'b0, 16'hFFFF, 16'h8006};
    vectors[9]  = '{1'b0, 1'b1, 16'h1234, 16'h1234};
    vectors[10] = '{1'b0, 1'b1, 16'hABCD, 16'hABCD};
    vectors[11] = '{1'b1, 1'b1, 16'h5A5A, 16'h0000};
    vectors[12] = '{1'b0, 1'b1, 16'h5A5A, 16'h5A5A};

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vectors[i].rst, vectors[i].il, vectors[i].ir);
      check_output($sformatf("vector_%0d", i), vectors[i].exp);
    end

    // Outputs must not follow IR before the load edge.
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    check_output("seq_reset", 16'h0000);
    reset  = 1'b0;
    bus.IL = 1'b1;
    bus.IR = 16'h8006;
    #1;
    check_output("seq_pre_edge", 16'h0000);
    @(posedge clk);
    #1;
    check_output("seq_load_edge", 16'h8006);

    // IR wiggling between edges with IL low is ignored.
    bus.IL = 1'b0;
    bus.IR = 16'h1111;
    #2;
    bus.IR = 16'h2222;
    @(posedge clk);
    #1;
    bus.IR = 16'h3333;
    check_output("seq_hold_wiggle", 16'h8006);

    // Reset with IL low clears; a later edge with IL low keeps it cleared.
    apply_stimulus(1'b1, 1'b0, 16'hBEEF);
    check_output("seq_reset_mid", 16'h0000);
    apply_stimulus(1'b0, 1'b0, 16'hBEEF);
    check_output("seq_no_load_after_reset", 16'h0000);
    apply_stimulus(1'b0, 1'b1, 16'hBEEF);
    check_output("seq_reload", 16'hBEEF);

    // Randomized run against a model of the last word loaded since reset.
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    model_word = 16'h0000;
    check_output("rand_sync", model_word);
    for (int n = 0; n < 300; n++) begin
      logic        r_rst;
      logic        r_il;
      logic [15:0] r_ir;
      r_rst = ($urandom_range(0, 15) == 0);
      r_il  = $urandom_range(0, 1) == 1;
      r_ir  = 16'($urandom);
      apply_stimulus(r_rst, r_il, r_ir);
      if (r_rst) begin
        model_word = 16'h0000;
      end else if (r_il) begin
        model_word = r_ir;
      end
      check_output($sformatf("rand_%0d", n), model_word);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
